grid_mem_arbiter: RTL and testbench

- Shares one single-port grid row memory between three requesters: display scanner (req 0, read-only), update engine (req 1) and AXI4-Lite host register path (req 2).
- Grid is 32x32 cells stored as 32 rows of 32 bits.
- Accepts at most one command per cycle, issues it to the RAM one cycle later and routes read data back to the originating requester.

---
 rtl/grid_mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_grid_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter: shares one single-port grid row RAM (32 rows x 32 bits)
// between the display scanner (req 0, read-only), the update engine (req 1)
// and the AXI4-Lite host register path (req 2).
// One command is accepted per cycle and issued to the RAM on the next cycle.
// Read data is routed back to the originating requester by a tag pipeline.
// Optional statistics counters are built only when GRID_ARB_STATS_EN is defined.
module grid_mem_arbiter #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [2:0]          req_we,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_wdata,
  output logic [2:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [47:0]         stat_grants,
  output logic [15:0]         stat_starve
);

  localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);
  // One tag stage per cycle from acceptance until read data is on mem_rdata.
  localparam int unsigned TP_D = RD_LAT + 1;

  typedef enum logic {
    RR_ENG  = 1'b0,
    RR_HOST = 1'b1
  } rr_e;

  // Arbitration state
  rr_e             rr_q, rr_d;
  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

  // Issue registers
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Read tag pipeline and response registers
  logic [TP_D-1:0]       tag_vld_q, tag_vld_d;
  logic [TP_D-1:0][1:0]  tag_id_q, tag_id_d;
  logic [2:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

  // Combinational arbitration results
  logic              starve_mask;
  logic              others_valid;
  logic [2:0]        grant;
  logic              xfer;
  logic              sel_we;
  logic [1:0]        sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Priority arbitration: display first unless starving the others,
  // then round-robin between engine and host.
  always_comb begin
    starve_mask  = (starve_cnt_q >= SC_W'(STARVE_MAX));
    others_valid = req_valid[1] | req_valid[2];
    grant        = 3'b000;
    if (req_valid[0] && !starve_mask) begin
      grant = 3'b001;
    end else if (req_valid[1] && req_valid[2]) begin
      grant = (rr_q == RR_HOST) ? 3'b100 : 3'b010;
    end else if (req_valid[1]) begin
      grant = 3'b010;
    end else if (req_valid[2]) begin
      grant = 3'b100;
    end else if (req_valid[0]) begin
      grant = 3'b001;
    end
    // Nothing is accepted while reset is asserted, even with valid inputs.
    req_ready = grant & {3{ARESETN}};
    xfer      = |grant;
  end

  // Select the command fields of the granted requester; req_we[0] is ignored.
  always_comb begin
    sel_id    = 2'd0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = |(grant & req_we & 3'b110);
    for (int unsigned i = 0; i < 3; i++) begin
      if (grant[i]) begin
        sel_id    = 2'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state for round-robin pointer and starvation counter.
  always_comb begin
    rr_d = rr_q;
    if (grant[1]) begin
      rr_d = RR_HOST;
    end else if (grant[2]) begin
      rr_d = RR_ENG;
    end

    starve_cnt_d = starve_cnt_q;
    if (grant[1] || grant[2] || !others_valid) begin
      starve_cnt_d = '0;
    end else if (grant[0] && (starve_cnt_q < SC_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Next-state for the RAM issue stage, tag pipeline and response outputs.
  always_comb begin
    mem_en_d    = xfer;
    mem_we_d    = xfer & sel_we;
    mem_addr_d  = xfer ? sel_addr  : mem_addr_q;
    mem_wdata_d = xfer ? sel_wdata : mem_wdata_q;

    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = xfer & ~sel_we;
    tag_id_d[0]  = sel_id;
    for (int unsigned s = 1; s < TP_D; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    rsp_valid_d = 3'b000;
    rsp_rdata_d = rsp_rdata_q;
    if (tag_vld_q[TP_D-1]) begin
      rsp_valid_d = 3'(3'b001 << tag_id_q[TP_D-1]);
      rsp_rdata_d = mem_rdata;
    end
  end

  // Core state registers; reset kills in-flight tags and the RAM enable at once.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rr_q         <= RR_ENG;
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      rsp_valid_q  <= 3'b000;
      rsp_rdata_q  <= '0;
    end else begin
      rr_q         <= rr_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef GRID_ARB_STATS_EN
  logic [2:0][15:0] stat_gnt_q, stat_gnt_d;
  logic [15:0]      stat_st_q, stat_st_d;
  logic             starve_override;

  // Saturating per-requester grant counts and starvation-override count.
  always_comb begin
    starve_override = req_valid[0] & starve_mask & ~grant[0] & xfer;
    stat_gnt_d      = stat_gnt_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (grant[i] && (stat_gnt_q[i] != 16'hFFFF)) begin
        stat_gnt_d[i] = stat_gnt_q[i] + 16'd1;
      end
    end
    stat_st_d = stat_st_q;
    if (starve_override && (stat_st_q != 16'hFFFF)) begin
      stat_st_d = stat_st_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stat_gnt_q <= '0;
      stat_st_q  <= '0;
    end else begin
      stat_gnt_q <= stat_gnt_d;
      stat_st_q  <= stat_st_d;
    end
  end

  assign stat_grants = stat_gnt_q;
  assign stat_starve = stat_st_q;
`else
  assign stat_grants = '0;
  assign stat_starve = '0;
`endif

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Scoreboard bench for grid_mem_arbiter: directed command vectors with
// hand-derived grant patterns; a monitor checks RAM issue and read responses.
module tb_grid_mem_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned RL = 1;
  localparam int unsigned SM = 8;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic [2:0]      req_valid, req_ready, req_we;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [47:0]     stat_grants;
  logic [15:0]     stat_starve;

  grid_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .STARVE_MAX(SM)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_grants(stat_grants), .stat_starve(stat_starve)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hC0DE_0000 | 32'(i * 17);
  endfunction

  // RAM model, read latency 1
  logic          preload;
  logic [DW-1:0] ram [32];
  always @(posedge ACLK) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } mem_exp_t;
  typedef struct packed { logic [2:0] id; logic [DW-1:0] data; int cyc; } rsp_exp_t;
  mem_exp_t mq[$];
  rsp_exp_t rq[$];
  mem_exp_t me;
  rsp_exp_t re;

  logic [DW-1:0] shadow [32];
  logic [AW-1:0] ta [3];
  logic [DW-1:0] td [3];
  int n_cmp = 0;
  int n_err = 0;
  int exp_gr [3];
  int exp_st;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues to RAM or responds.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (!mem_en) chk("mem_we_idle", mem_we, 0);
      if (mem_en) begin
        if (mq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_mem_cmd: got addr %0h we %0b expected none at cycle %0d", mem_addr, mem_we, cyc);
        end else begin
          me = mq.pop_front();
          chk("mem_cyc", cyc, me.cyc);
          chk("mem_we", mem_we, me.we);
          chk("mem_addr", mem_addr, me.addr);
          if (me.we) chk("mem_wdata", mem_wdata, me.data);
        end
      end
      if (rsp_valid != 3'b000) begin
        if (rq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rsp: got rsp_valid %0b expected none at cycle %0d", rsp_valid, cyc);
        end else begin
          re = rq.pop_front();
          chk("rsp_cyc", cyc, re.cyc);
          chk("rsp_valid", rsp_valid, re.id);
          chk("rsp_rdata", rsp_rdata, re.data);
        end
      end
    end
  end

  // Drive one cycle of requests; expected grant vector is given by the caller.
  task automatic step(input logic [2:0] v, input logic [2:0] we, input logic [2:0] exp_rdy, input string nm);
    mem_exp_t m;
    rsp_exp_t r;
    logic     w;
    req_valid = v;
    req_we    = we;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*AW +: AW]  = ta[i];
      req_wdata[i*DW +: DW] = td[i];
    end
    @(negedge ACLK);
    chk({nm, "_ready"}, req_ready, exp_rdy);
    for (int i = 0; i < 3; i++) begin
      if (exp_rdy[i]) begin
        w = we[i] && (i != 0);
        m = '{we: w, addr: ta[i], data: td[i], cyc: cyc + 1};
        mq.push_back(m);
        if (w) begin
          shadow[ta[i]] = td[i];
        end else begin
          r = '{id: 3'(1 << i), data: shadow[ta[i]], cyc: cyc + 2 + RL};
          rq.push_back(r);
        end
        exp_gr[i]++;
      end
    end
    if (v[0] && !exp_rdy[0] && (exp_rdy != 3'b000)) exp_st++;
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(3'b000, 3'b000, 3'b000, "idle");
  endtask

  // Asynchronous reset mid-run; pending expectations are discarded.
  task automatic do_reset();
    ARESETN = 1'b0;
    #1;
    mq.delete();
    rq.delete();
    for (int i = 0; i < 3; i++) exp_gr[i] = 0;
    exp_st = 0;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  task automatic check_stats(input string nm);
`ifdef GRID_ARB_STATS_EN
    chk({nm, "_g0"}, stat_grants[15:0], 16'(exp_gr[0]));
    chk({nm, "_g1"}, stat_grants[31:16], 16'(exp_gr[1]));
    chk({nm, "_g2"}, stat_grants[47:32], 16'(exp_gr[2]));
    chk({nm, "_starve"}, stat_starve, 16'(exp_st));
`else
    chk({nm, "_grants_off"}, stat_grants, 0);
    chk({nm, "_starve_off"}, stat_starve, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
    for (int i = 0; i < 3; i++) begin ta[i] = '0; td[i] = '0; exp_gr[i] = 0; end
    exp_st    = 0;
    ARESETN   = 1'b1;
    preload   = 1'b1;
    req_valid = 3'b111;
    req_we    = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    #2 ARESETN = 1'b0;
    @(posedge ACLK);
    #1 preload = 1'b0;
    @(negedge ACLK);
    chk("reset_req_ready", req_ready, 3'b000);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_rsp_valid", rsp_valid, 3'b000);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;

    // First cycle out of reset: display wins
    ta[0] = 5'd4; ta[1] = 5'd1; ta[2] = 5'd2;
    step(3'b111, 3'b000, 3'b001, "first");
    idle(1);

    // Host write then host read of row 3
    ta[2] = 5'd3; td[2] = 32'hDEADBEEF;
    step(3'b100, 3'b100, 3'b100, "host_wr");
    step(3'b100, 3'b000, 3'b100, "host_rd");
    idle(3);

    // Engine write then read of the same row returns the new data
    ta[1] = 5'd7; td[1] = 32'h1234_5678;
    step(3'b010, 3'b010, 3'b010, "eng_wr");
    step(3'b010, 3'b000, 3'b010, "eng_rd");

    // Back-to-back display reads
    for (int a = 10; a < 14; a++) begin
      ta[0] = 5'(a);
      step(3'b001, 3'b000, 3'b001, "b2b_rd");
    end
    idle(3);

    // Round-robin from reset state (rr favours the engine)
    do_reset();
    ta[1] = 5'd1; ta[2] = 5'd2;
    for (int k = 0; k < 6; k++)
      step(3'b110, 3'b000, (k % 2 == 0) ? 3'b010 : 3'b100, "rr");
    idle(1);

    // Starvation: 8 display grants then one host grant, twice
    ta[0] = 5'd20; ta[2] = 5'd21; td[2] = 32'hA5A5_0F0F;
    for (int k = 0; k < 18; k++)
      step(3'b101, 3'b100, (k % 9 == 8) ? 3'b100 : 3'b001, "starve");
    idle(3);
    check_stats("stats");

    // Reset with two reads in flight
    ta[1] = 5'd5;
    step(3'b010, 3'b000, 3'b010, "fl_a");
    ta[1] = 5'd6;
    step(3'b010, 3'b000, 3'b010, "fl_b");
    req_valid = 3'b000;
    do_reset();
    idle(4);
    ta[1] = 5'd5;
    step(3'b010, 3'b000, 3'b010, "post_rst_rd");
    idle(4);
    check_stats("stats_post_rst");

    chk("mem_queue_drained", mq.size(), 0);
    chk("rsp_queue_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
